mult_simd_pipelined: RTL and testbench
======================================

MULT_SIMD_PIPELINED -- requirements
Module: mult_simd_pipelined

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- A_CHOP_SIZE, 8, A operand width; even, >=4.
- B_CHOP_SIZE, 8, B operand width; even, >=4.
- LATENCY, 2, cycles from accepted input to registered output; >=1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- ce, in, 1, clock enable; low freezes all state.
- in_valid, in, 1, operand sample qualifier.
- A, in, A_CHOP_SIZE, multiplicand.
- B, in, B_CHOP_SIZE, multiplier.
- A_sign, in, 1, 1 = A signed (two's complement), 0 = unsigned.
- B_sign, in, 1, as A_sign for B.
- HALF_0, in, 1, 1 = two independent half-width lanes, 0 = one full product.
- acc_en, in, 1, add the product to the accumulator.
- acc_clr, in, 1, load the product into the accumulator, discarding the old value.
- out_valid, out, 1, C qualifier.
- C, out, A_CHOP_SIZE+B_CHOP_SIZE, product or accumulator value.

REQ-003 Clock is clk; reset is asynchronous, active-high, named reset.

Function
REQ-004 A sample SHALL be accepted on a rising clk edge when in_valid=1 and ce=1; all sideband inputs are sampled with it.
REQ-005 Full mode (HALF_0=0): C SHALL be A*B, each operand sign-extended only if its sign bit is set, truncated to A_CHOP_SIZE+B_CHOP_SIZE bits.
REQ-006 Half mode (HALF_0=1):
- Low lane: C[PH-1:0] SHALL be A[AH-1:0]*B[BH-1:0].
- High lane: C[2PH-1:PH] SHALL be A[top AH]*B[top BH].
- Widths: AH=A_CHOP_SIZE/2, BH=B_CHOP_SIZE/2, PH=AH+BH.
- Signedness: A_sign/B_sign apply per lane, using each lane's top bit as its sign.
REQ-007 out_valid and C SHALL appear exactly LATENCY ce-enabled cycles after acceptance; ce=0 cycles do not count.
REQ-008 HALF_0, acc_en, acc_clr and signs SHALL travel with their sample; a mode change between consecutive samples needs no bubble.
REQ-009 Accumulation SHALL be resolved in the final stage for valid samples.
- acc_clr=1 (priority over acc_en): acc = product.
- acc_en=1: acc = acc + product.
- Neither: acc unchanged; C = product.
REQ-010 Accumulation SHALL wrap modulo 2^(A+B) in full mode and modulo 2^PH per lane in half mode; no carry crosses the lane boundary.
REQ-011 Accumulator contents SHALL be reinterpreted bitwise on a mode switch, without conversion.
REQ-012 Invalid samples SHALL propagate out_valid=0 and SHALL NOT change the accumulator; C is don't-care when out_valid=0.
REQ-013 ce=0 SHALL hold all pipeline registers, accumulator, out_valid and C.

Reset
REQ-014 reset=1 SHALL asynchronously clear all valid bits, the accumulator and C to 0; out_valid=0 while reset is held.
REQ-015 Samples in flight at reset SHALL be discarded; the first sample accepted after deassertion emerges LATENCY enabled cycles later.

Structure
REQ-016 A shared package SHALL hold the mode encoding (full/half) and a function for lane width PH.
REQ-017 One sub-module, mult_simd_pp_core, SHALL be natural: combinational Baugh-Wooley partial-product generation and summation with lane masking, registered by the parent.
REQ-018 Pipeline stages beyond the first SHALL be a parametrised register chain of depth LATENCY-1.

Verification
REQ-019 Full signed: A=0x80, B=0x80, signs=1 -> C=0x4000, out_valid after 2 cycles.
REQ-020 Full unsigned: A=0xFF, B=0xFF, signs=0 -> C=0xFE01.
REQ-021 Half signed: A=0xF3, B=0x2F, signs=1 -> C=0xFEFD (lanes -2, -3).
REQ-022 Accumulate wrap: two samples 0xFF*0xFF unsigned, acc_clr then acc_en -> C=0xFE01 then 0xFC02.
REQ-023 Lane isolation: half unsigned, A=0x0F, B=0x0F twice, acc_clr then acc_en -> low lane 0xE1 then 0xC2, high lane 0x00.
REQ-024 Stall and reset:
- ce=0 for 3 cycles mid-flight -> C/out_valid frozen; latency extends by 3.
- reset pulse with 2 samples in flight -> no out_valid, accumulator 0.

Source files
------------

// File: rtl/mult_simd_pipelined_pkg.sv
// Shared definitions for the SIMD pipelined multiplier.
//   mode_e      : operating mode, full-width product or two half-width lanes
//   lane_width  : product width of one half-width lane (AH + BH)
package mult_simd_pipelined_pkg;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_HALF = 1'b1
  } mode_e;

  function automatic int lane_width(input int a_w, input int b_w);
    return (a_w / 2) + (b_w / 2);
  endfunction

endpackage

// File: rtl/mult_simd_pp_core.sv
// Combinational Baugh-Wooley multiplier with half-width lane masking.
// The parent registers the result.
// Ports:
//   a, b           : operands
//   a_sign, b_sign : 1 = operand is two's complement, 0 = unsigned
//   mode           : MODE_FULL gives one full product, MODE_HALF gives two
//                    independent lane products packed {hi_lane, lo_lane}
//   product        : A_W+B_W bit result (truncated)
module mult_simd_pp_core
  import mult_simd_pipelined_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               a_sign,
  input  logic               b_sign,
  input  mode_e              mode,
  output logic [A_W+B_W-1:0] product
);

  localparam int PW = A_W + B_W;
  localparam int AH = A_W / 2;
  localparam int BH = B_W / 2;
  localparam int PH = lane_width(A_W, B_W);

  logic          pp;
  logic          neg;
  logic [PW-1:0] s_full;
  logic [PH-1:0] s_lo;
  logic [PH-1:0] s_hi;

  // A partial-product bit whose weight is negative (exactly one factor is
  // the sign bit of a signed operand) is entered inverted and a constant
  // 2^k is subtracted: (1 - x)*2^k - 2^k = -x*2^k. This is the Baugh-Wooley
  // form, applied separately to the full array and to each lane sub-array.
  // Cross-lane terms never enter the lane sums, so no carry or sign
  // correction leaks across the lane boundary.
  always_comb begin
    pp     = 1'b0;
    neg    = 1'b0;
    s_full = '0;
    s_lo   = '0;
    s_hi   = '0;
    for (int i = 0; i < A_W; i++) begin
      for (int j = 0; j < B_W; j++) begin
        pp  = a[i] & b[j];
        neg = ((i == A_W-1) && a_sign) != ((j == B_W-1) && b_sign);
        s_full = s_full + (PW'(pp ^ neg) << (i + j)) - (PW'(neg) << (i + j));
        if ((i < AH) && (j < BH)) begin
          neg  = ((i == AH-1) && a_sign) != ((j == BH-1) && b_sign);
          s_lo = s_lo + (PH'(pp ^ neg) << (i + j)) - (PH'(neg) << (i + j));
        end else if ((i >= AH) && (j >= BH)) begin
          neg  = ((i == A_W-1) && a_sign) != ((j == B_W-1) && b_sign);
          s_hi = s_hi + (PH'(pp ^ neg) << (i - AH + j - BH))
                      - (PH'(neg) << (i - AH + j - BH));
        end
      end
    end
    product = (mode == MODE_HALF) ? {s_hi, s_lo} : s_full;
  end

endmodule

// File: rtl/mult_simd_pipelined.sv
// Pipelined SIMD multiply / multiply-accumulate.
// A sample (operands plus sideband) is accepted when in_valid & ce. The
// product is formed combinationally, carried through LATENCY-1 register
// stages, and the final registered stage resolves accumulation and drives C.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   ce             : clock enable, low freezes every register
//   in_valid       : sample qualifier
//   A, B           : operands
//   A_sign, B_sign : per-operand signedness
//   HALF_0         : 1 = two half-width lanes, 0 = one full product
//   acc_en, acc_clr: accumulate / load accumulator (clr wins)
//   out_valid, C   : result qualifier and result
module mult_simd_pipelined
  import mult_simd_pipelined_pkg::*;
#(
  parameter int A_CHOP_SIZE = 8,
  parameter int B_CHOP_SIZE = 8,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  input  logic                           in_valid,
  input  logic [A_CHOP_SIZE-1:0]         A,
  input  logic [B_CHOP_SIZE-1:0]         B,
  input  logic                           A_sign,
  input  logic                           B_sign,
  input  logic                           HALF_0,
  input  logic                           acc_en,
  input  logic                           acc_clr,
  output logic                           out_valid,
  output logic [A_CHOP_SIZE+B_CHOP_SIZE-1:0] C
);

  localparam int PW = A_CHOP_SIZE + B_CHOP_SIZE;
  localparam int PH = lane_width(A_CHOP_SIZE, B_CHOP_SIZE);

  if ((A_CHOP_SIZE % 2 != 0) || (A_CHOP_SIZE < 4) ||
      (B_CHOP_SIZE % 2 != 0) || (B_CHOP_SIZE < 4) || (LATENCY < 1)) begin : g_bad_param
    $error("mult_simd_pipelined: operand widths must be even and >= 4, LATENCY >= 1");
  end

  // Sideband travels with its product so modes can change sample to sample.
  typedef struct packed {
    logic          valid;
    mode_e         mode;
    logic          acc_en;
    logic          acc_clr;
    logic [PW-1:0] product;
  } stage_t;

  logic [PW-1:0] product_comb;
  stage_t        pipe_d;
  stage_t        pipe_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [PW-1:0] c_d;

  mult_simd_pp_core #(
    .A_W (A_CHOP_SIZE),
    .B_W (B_CHOP_SIZE)
  ) u_core (
    .a       (A),
    .b       (B),
    .a_sign  (A_sign),
    .b_sign  (B_sign),
    .mode    (mode_e'(HALF_0)),
    .product (product_comb)
  );

  always_comb begin
    pipe_d.valid   = in_valid;
    pipe_d.mode    = mode_e'(HALF_0);
    pipe_d.acc_en  = acc_en;
    pipe_d.acc_clr = acc_clr;
    pipe_d.product = product_comb;
  end

  if (LATENCY > 1) begin : g_chain
    stage_t chain [LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LATENCY-1; i++) chain[i] <= '0;
      end else if (ce) begin
        chain[0] <= pipe_d;
        for (int i = 1; i < LATENCY-1; i++) chain[i] <= chain[i-1];
      end
    end

    assign pipe_q = chain[LATENCY-2];
  end else begin : g_no_chain
    assign pipe_q = pipe_d;
  end

  // Final stage. The accumulator is plain bits; a mode switch simply reads
  // the same bits as one word or as two lanes. In half mode each lane adds
  // on its own so the low-lane carry is dropped.
  always_comb begin
    acc_d = acc_q;
    c_d   = C;
    if (pipe_q.valid) begin
      c_d = pipe_q.product;
      if (pipe_q.acc_clr) begin
        acc_d = pipe_q.product;
      end else if (pipe_q.acc_en) begin
        if (pipe_q.mode == MODE_HALF) begin
          acc_d = {acc_q[PW-1:PH] + pipe_q.product[PW-1:PH],
                   acc_q[PH-1:0]  + pipe_q.product[PH-1:0]};
        end else begin
          acc_d = acc_q + pipe_q.product;
        end
        c_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      C         <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      acc_q     <= acc_d;
      C         <= c_d;
      out_valid <= pipe_q.valid;
    end
  end

endmodule

// File: tb/tb_mult_simd_pipelined.sv
module tb_mult_simd_pipelined;

  localparam int AW  = 8;
  localparam int BW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          in_valid;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic          A_sign;
  logic          B_sign;
  logic          HALF_0;
  logic          acc_en;
  logic          acc_clr;
  logic          out_valid;
  logic [15:0]   C;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0]  sb [$];
  logic [15:0]  acc_m = '0;
  logic [15:0]  cur_exp = '0;
  logic [LAT-1:0] vpipe = '0;

  mult_simd_pipelined #(
    .A_CHOP_SIZE (AW),
    .B_CHOP_SIZE (BW),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .A_sign    (A_sign),
    .B_sign    (B_sign),
    .HALF_0    (HALF_0),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .C         (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic longint ext(input logic [7:0] v, input int w, input bit s);
    if (s && v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic logic [15:0] mprod(input logic [7:0] a, input logic [7:0] b,
                                        input bit as, input bit bs, input bit hf);
    logic [7:0] a_lo, a_hi, b_lo, b_hi, p_lo, p_hi;
    if (!hf) return 16'(ext(a, 8, as) * ext(b, 8, bs));
    a_lo = {4'h0, a[3:0]};
    a_hi = {4'h0, a[7:4]};
    b_lo = {4'h0, b[3:0]};
    b_hi = {4'h0, b[7:4]};
    p_lo = 8'(ext(a_lo, 4, as) * ext(b_lo, 4, bs));
    p_hi = 8'(ext(a_hi, 4, as) * ext(b_hi, 4, bs));
    return {p_hi, p_lo};
  endfunction

  // Drive one cycle of inputs at the falling edge; accepted samples push
  // their expected C (literal if given, otherwise the reference model).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit as, input bit bs,
                      input bit hf, input bit en, input bit clr, input bit v, input bit ce_i,
                      input bit use_exp, input logic [15:0] exp_c);
    logic [15:0] p, r;
    @(negedge clk);
    A = a; B = b; A_sign = as; B_sign = bs; HALF_0 = hf;
    acc_en = en; acc_clr = clr; in_valid = v; ce = ce_i;
    if (v && ce_i) begin
      p = mprod(a, b, as, bs, hf);
      r = p;
      if (clr) begin
        acc_m = p;
      end else if (en) begin
        acc_m = hf ? {acc_m[15:8] + p[15:8], acc_m[7:0] + p[7:0]} : acc_m + p;
        r = acc_m;
      end
      sb.push_back(use_exp ? exp_c : r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
  endtask

  // Output monitor: a valid-bit model shifted on enabled edges decides when
  // out_valid is due; the scoreboard supplies C.
  always @(posedge clk) begin
    logic ce_s, iv_s;
    ce_s = ce;
    iv_s = in_valid;
    #1;
    if (reset) begin
      vpipe = '0;
    end else if (ce_s) begin
      vpipe = {vpipe[LAT-2:0], iv_s};
      if (vpipe[LAT-1]) begin
        if (sb.size() == 0) check("sb_underflow", 32'd0, 32'd1);
        else cur_exp = sb.pop_front();
      end
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, vpipe[LAT-1]});
    if (vpipe[LAT-1]) check("c", {16'd0, C}, {16'd0, cur_exp});
  end

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    A_sign = 1'b0; B_sign = 1'b0; HALF_0 = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_c", {16'd0, C}, 32'd0);
    reset = 1'b0;

    send(8'h80, 8'h80, 1, 1, 0, 0, 0, 1, 1, 1, 16'h4000);
    send(8'hFF, 8'hFF, 0, 0, 0, 0, 0, 1, 1, 1, 16'hFE01);
    send(8'hF3, 8'h2F, 1, 1, 1, 0, 0, 1, 1, 1, 16'hFEFD);
    send(8'hFF, 8'hFF, 0, 0, 0, 0, 1, 1, 1, 1, 16'hFE01);
    send(8'hFF, 8'hFF, 0, 0, 0, 1, 0, 1, 1, 1, 16'hFC02);
    send(8'h0F, 8'h0F, 0, 0, 1, 0, 1, 1, 1, 1, 16'h00E1);
    send(8'h0F, 8'h0F, 0, 0, 1, 1, 0, 1, 1, 1, 16'h00C2);
    send(8'h02, 8'h03, 0, 0, 0, 1, 0, 1, 1, 1, 16'h00C8);
    send(8'h11, 8'h11, 0, 0, 1, 1, 0, 1, 1, 1, 16'h01C9);
    send(8'h7F, 8'h7F, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0000);
    send(8'h01, 8'h01, 0, 0, 0, 1, 0, 1, 1, 1, 16'h01CA);
    idle(4);

    // Stall while results are in flight and one is on the output.
    send(8'h05, 8'h07, 0, 0, 0, 0, 1, 1, 1, 1, 16'h0023);
    send(8'h03, 8'h03, 0, 0, 0, 1, 0, 1, 1, 1, 16'h002C);
    send(8'hFE, 8'h03, 1, 0, 0, 0, 0, 1, 1, 1, 16'hFFFA);
    repeat (3) send(8'h09, 8'h09, 0, 0, 0, 1, 0, 1, 0, 0, 16'h0);
    idle(4);

    // Reset with two samples in flight.
    send(8'h10, 8'h10, 0, 0, 0, 0, 1, 1, 1, 0, 16'h0);
    send(8'h20, 8'h10, 0, 0, 0, 1, 0, 1, 1, 0, 16'h0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    sb.delete();
    acc_m = '0;
    repeat (2) @(negedge clk);
    check("reset_c2", {16'd0, C}, 32'd0);
    reset = 1'b0;
    send(8'h03, 8'h05, 0, 0, 0, 1, 0, 1, 1, 1, 16'h000F);
    idle(4);

    for (int k = 0; k < 60; k++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0), 0, 16'h0);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
